// File: rtl/inst_loader_pkg.sv
// ----------------------------------------------------------------------------
// inst_loader_pkg
//   Shared definitions for the boot-time instruction loader: the instruction
//   word width, the loader FSM state encoding and a small helper that tells
//   whether a state still accepts bytes from the receiver.
// ----------------------------------------------------------------------------
package inst_loader_pkg;

    localparam int LDR_WIDTH = 32;

    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_ERR  = 2'd3
    } ldr_state_e;

    // Header and data phases both take bytes; RUN and ERR never do.
    function automatic logic ldr_accepts(input ldr_state_e s);
        return (s == S_LEN) || (s == S_LOAD);
    endfunction

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// ----------------------------------------------------------------------------
// inst_loader_byte_assembler
//   Packs accepted bytes MSB-first into a WIDTH-bit word with a 2-bit byte
//   counter. The same instance assembles the length header and every data
//   word.
// Ports
//   clk          in   system clock
//   rstn         in   synchronous active-low reset
//   clear_i      in   drop any partial word and restart at byte 0
//   in_valid_i   in   a byte is accepted this cycle
//   in_data_i    in   the accepted byte
//   word_o       out  shift register contents (a complete word while word_done_o=1)
//   word_done_o  out  one-cycle pulse in the cycle after the 4th byte is accepted
// ----------------------------------------------------------------------------
module inst_loader_byte_assembler #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear_i,
    input  logic             in_valid_i,
    input  logic [7:0]       in_data_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_done_o
);

    logic [WIDTH-1:0] word_q, word_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             done_q, done_d;

    // The counter wraps 3->0 on its own, so the byte accepted in the same
    // cycle as word_done_o already lands as byte 0 of the next word.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = 2'd0;
        end else if (in_valid_i) begin
            word_d = {word_q[WIDTH-9:0], in_data_i};
            cnt_d  = cnt_q + 2'd1;
            done_d = (cnt_q == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            word_q <= '0;
            cnt_q  <= 2'd0;
            done_q <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign word_o      = word_q;
    assign word_done_o = done_q;

endmodule

// File: rtl/inst_loader.sv
// ----------------------------------------------------------------------------
// inst_loader
//   Boot-time program loader in front of the core's instruction port. Reads a
//   4-byte big-endian word count, then that many 32-bit big-endian words, and
//   writes them to instruction memory at word addresses 0,1,2,... The core is
//   held in reset until the last word has been written.
// Ports
//   clk           in   system clock
//   rstn          in   synchronous active-low reset
//   rx_data       in   received byte
//   rx_valid      in   rx_data valid
//   rx_ready      out  loader accepts a byte (transfer on rx_valid && rx_ready)
//   imem_we       out  imem write strobe, one cycle per word
//   imem_waddr    out  imem word address
//   imem_wdata    out  imem write data
//   core_rstn     out  core reset, active-low; released once loading is done
//   loaded_words  out  number of words written so far
//   busy          out  loader is reading the header or data
//   err           out  sticky: header count exceeds imem capacity
// ----------------------------------------------------------------------------
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int WIDTH  = LDR_WIDTH,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [WIDTH-1:0]  imem_wdata,
    output logic              core_rstn,
    output logic [31:0]       loaded_words,
    output logic              busy,
    output logic              err
);

    // 33 bits so that a capacity of 2**32 words would still compare correctly.
    localparam logic [32:0] CAPACITY = 33'(1) << ADDR_W;

    ldr_state_e        state_q;
    logic [31:0]       len_q;
    logic              rx_ready_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_waddr_q;
    logic [WIDTH-1:0]  imem_wdata_q;
    logic              core_rstn_q;
    logic [31:0]       loaded_words_q;
    logic [31:0]       loaded_words_d;
    logic              busy_q;
    logic              err_q;

    logic              asm_accept;
    logic              asm_clear;
    logic [WIDTH-1:0]  asm_word;
    logic              asm_done;
    logic              len_too_big;

    assign asm_accept     = rx_valid && rx_ready_q;
    assign asm_clear      = !ldr_accepts(state_q);
    assign loaded_words_d = loaded_words_q + 32'd1;
    assign len_too_big    = ({1'b0, asm_word[31:0]} > CAPACITY);

    inst_loader_byte_assembler #(
        .WIDTH (WIDTH)
    ) u_assembler (
        .clk         (clk),
        .rstn        (rstn),
        .clear_i     (asm_clear),
        .in_valid_i  (asm_accept),
        .in_data_i   (rx_data),
        .word_o      (asm_word),
        .word_done_o (asm_done)
    );

    // All outputs are registered. rx_ready/busy are loaded with the value that
    // matches the state being entered, so they follow the state with no lag.
    // A data word is written the cycle after its 4th byte, using the old
    // loaded_words as the address.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= S_LEN;
            len_q          <= '0;
            rx_ready_q     <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_waddr_q   <= '0;
            imem_wdata_q   <= '0;
            core_rstn_q    <= 1'b0;
            loaded_words_q <= '0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                S_LEN: begin
                    rx_ready_q <= 1'b1;
                    busy_q     <= 1'b1;
                    if (asm_done) begin
                        len_q <= asm_word[31:0];
                        if (asm_word[31:0] == 32'd0) begin
                            // Nothing to load: release the core straight away.
                            state_q     <= S_RUN;
                            core_rstn_q <= 1'b1;
                            rx_ready_q  <= 1'b0;
                            busy_q      <= 1'b0;
                        end else if (len_too_big) begin
                            state_q    <= S_ERR;
                            err_q      <= 1'b1;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    rx_ready_q <= 1'b1;
                    busy_q     <= 1'b1;
                    if (asm_done) begin
                        imem_we_q      <= 1'b1;
                        imem_waddr_q   <= loaded_words_q[ADDR_W-1:0];
                        imem_wdata_q   <= asm_word;
                        loaded_words_q <= loaded_words_d;
                        if (loaded_words_d == len_q) begin
                            state_q    <= S_RUN;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    // Reached here from the last write, so core_rstn rises
                    // one cycle after the final imem_we pulse.
                    rx_ready_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    core_rstn_q <= 1'b1;
                end
                S_ERR: begin
                    rx_ready_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    core_rstn_q <= 1'b0;
                    err_q       <= 1'b1;
                end
                default: begin
                    state_q <= S_LEN;
                end
            endcase
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_waddr   = imem_waddr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_rstn    = core_rstn_q;
    assign loaded_words = loaded_words_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// ----------------------------------------------------------------------------
// tb_inst_loader
//   Self-checking bench for inst_loader built with a 16-word imem (ADDR_W=4)
//   so that the capacity boundary is reachable. Each load builds the byte
//   stream from a word count and a list of words; expected writes, addresses,
//   timing and final status come from the stream itself.
// ----------------------------------------------------------------------------
module tb_inst_loader;

    localparam int ADDR_W = 4;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_rstn;
    logic [31:0]       loaded_words;
    logic              busy;
    logic              err;

    int          cyc = 0;
    int          assertCount = 0;
    int          failCount = 0;
    int          rstCycle = -1;
    int          wrAddr[$];
    logic [31:0] wrData[$];
    int          wrEdge[$];
    int          acceptEdge[$];
    logic [31:0] dataQ[$];
    logic [31:0] presetData[$];

    inst_loader #(
        .WIDTH  (32),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_rstn    (core_rstn),
        .loaded_words (loaded_words),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    // cyc numbers the rising edges; a value seen at a falling edge belongs to edge cyc.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (imem_we) begin
                wrAddr.push_back(int'(imem_waddr));
                wrData.push_back(imem_wdata);
                wrEdge.push_back(cyc);
            end
            if (core_rstn && rstCycle < 0) rstCycle = cyc;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offers one byte after `gap` idle cycles and waits (bounded) for the handshake.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        repeat (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int w = 0; w < 20 && rx_ready !== 1'b1; w++) @(negedge clk);
        checkOutput("byte_accept", 64'(rx_ready), 64'd1);
        acceptEdge.push_back(cyc + 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rstn     = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic clearMonitor();
        wrAddr.delete();
        wrData.delete();
        wrEdge.delete();
        acceptEdge.delete();
        rstCycle = -1;
    endtask

    // Sends a header of `len` plus its data words (none if len exceeds the
    // capacity), trails some bytes that must be ignored, then checks everything.
    task automatic loadAndCheck(input string tag, input logic [31:0] len, input bit randGap,
                                input int gap, input bit doReset);
        logic [31:0] hdr;
        logic [31:0] w;
        bit          overCap;
        int          expWrites;
        int          n;
        int          expRst;
        if (doReset) applyReset();
        clearMonitor();
        dataQ.delete();
        overCap   = (len > 32'(CAP));
        expWrites = overCap ? 0 : int'(len);
        for (int k = 0; k < expWrites; k++) begin
            if (presetData.size() == expWrites) dataQ.push_back(presetData[k]);
            else dataQ.push_back($urandom);
        end
        presetData.delete();

        hdr = len;
        for (int i = 3; i >= 0; i--)
            applyStimulus(hdr[i*8 +: 8], randGap ? int'($urandom_range(0, 3)) : gap);
        for (int k = 0; k < expWrites; k++) begin
            w = dataQ[k];
            for (int i = 3; i >= 0; i--)
                applyStimulus(w[i*8 +: 8], randGap ? int'($urandom_range(0, 3)) : gap);
        end

        repeat (4) @(negedge clk);
        checkOutput({tag, "_rx_ready_idle"}, 64'(rx_ready), 64'd0);
        rx_valid = 1'b1;
        repeat (3) begin
            rx_data = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        @(negedge clk);

        checkOutput({tag, "_nwrites"}, 64'(wrAddr.size()), 64'(expWrites));
        n = (wrAddr.size() < expWrites) ? wrAddr.size() : expWrites;
        for (int k = 0; k < n; k++) begin
            checkOutput($sformatf("%s_w%0d_addr", tag, k), 64'(wrAddr[k]), 64'(k));
            checkOutput($sformatf("%s_w%0d_data", tag, k), 64'(wrData[k]), 64'(dataQ[k]));
            checkOutput($sformatf("%s_w%0d_edge", tag, k), 64'(wrEdge[k]),
                        64'(acceptEdge[4 + 4*k + 3] + 1));
        end
        checkOutput({tag, "_loaded_words"}, 64'(loaded_words), 64'(expWrites));
        checkOutput({tag, "_core_rstn"}, 64'(core_rstn), overCap ? 64'd0 : 64'd1);
        checkOutput({tag, "_err"}, 64'(err), overCap ? 64'd1 : 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        if (!overCap) begin
            expRst = (expWrites == 0) ? acceptEdge[3] + 1 : acceptEdge[4*expWrites + 3] + 2;
            checkOutput({tag, "_core_rstn_edge"}, 64'(rstCycle), 64'(expRst));
        end
    endtask

    initial begin
        $display("[TB] inst_loader bench start");

        // Reset values while rstn is held low, then S_LEN behaviour once released.
        repeat (3) @(negedge clk);
        checkOutput("rst_rx_ready", 64'(rx_ready), 64'd0);
        checkOutput("rst_imem_we", 64'(imem_we), 64'd0);
        checkOutput("rst_imem_waddr", 64'(imem_waddr), 64'd0);
        checkOutput("rst_imem_wdata", 64'(imem_wdata), 64'd0);
        checkOutput("rst_core_rstn", 64'(core_rstn), 64'd0);
        checkOutput("rst_loaded_words", 64'(loaded_words), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("len_busy", 64'(busy), 64'd1);
        checkOutput("len_rx_ready", 64'(rx_ready), 64'd1);

        // Two words, back to back.
        presetData.push_back(32'hDEADBEEF);
        presetData.push_back(32'h12345678);
        loadAndCheck("two_words", 32'd2, 1'b0, 0, 1'b1);

        // Empty program.
        loadAndCheck("empty", 32'd0, 1'b0, 0, 1'b1);

        // One word over capacity, and far over capacity.
        loadAndCheck("over_cap", 32'd17, 1'b0, 0, 1'b1);
        loadAndCheck("over_64k", 32'h0001_0000, 1'b0, 0, 1'b1);
        loadAndCheck("over_max", 32'hFFFF_FFFF, 1'b1, 0, 1'b1);

        // One word with 5-cycle gaps between bytes.
        presetData.push_back(32'hCAFE_F00D);
        loadAndCheck("gapped", 32'd1, 1'b0, 5, 1'b1);

        // Reset after two data bytes of word 0, then a fresh load.
        applyReset();
        clearMonitor();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("midrst_rx_ready", 64'(rx_ready), 64'd0);
        checkOutput("midrst_imem_we", 64'(imem_we), 64'd0);
        checkOutput("midrst_core_rstn", 64'(core_rstn), 64'd0);
        checkOutput("midrst_loaded_words", 64'(loaded_words), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_err", 64'(err), 64'd0);
        checkOutput("midrst_nwrites", 64'(wrAddr.size()), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy_after", 64'(busy), 64'd1);
        presetData.push_back(32'hAABBCCDD);
        loadAndCheck("reload", 32'd1, 1'b0, 0, 1'b0);

        // Exactly full imem, back to back.
        loadAndCheck("full", 32'd16, 1'b0, 0, 1'b1);

        // Random lengths, data and gaps.
        for (int r = 0; r < 8; r++)
            loadAndCheck($sformatf("rnd%0d", r), 32'($urandom_range(0, CAP)), 1'b1, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
